// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: access-size encodings,
// load/store select values and the responder state type.
package mem_pkg;

    // funct3-style access sizes
    localparam logic [2:0] SZ_B   = 3'b000;
    localparam logic [2:0] SZ_H   = 3'b001;
    localparam logic [2:0] SZ_W   = 3'b010;
    localparam logic [2:0] SZ_D   = 3'b011;
    localparam logic [2:0] SZ_BU  = 3'b100;
    localparam logic [2:0] SZ_HU  = 3'b101;
    localparam logic [2:0] SZ_WU  = 3'b110;
    localparam logic [2:0] SZ_ILL = 3'b111;

    localparam logic MEM_LOAD  = 1'b0;
    localparam logic MEM_STORE = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane handling for one 64-bit word: load extract with sign or
// zero extension, and byte-enable merge of right-justified store data.
// Build option MEM_MISALIGN_TRAP_EN: when defined, a misaligned H/W/D access
// is flagged as an error; otherwise the low address bits are forced to the
// natural alignment of the access size.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [2:0]  lane,
    input  logic [63:0] rdata,
    input  logic [63:0] wdata,
    output logic [63:0] ld_data,
    output logic [63:0] wr_word,
    output logic        err
);

    logic [2:0]  eff_lane;
    logic [63:0] bmask;
    logic [5:0]  shamt;
    logic [63:0] raw;
    logic [63:0] wmask;
    logic        misalign;

`ifdef MEM_MISALIGN_TRAP_EN
    // Natural-alignment check per access width
    always_comb begin
        misalign = 1'b0;
        case (size[1:0])
            2'b01:   misalign = lane[0];
            2'b10:   misalign = |lane[1:0];
            2'b11:   misalign = |lane;
            default: misalign = 1'b0;
        endcase
    end
`else
    // Misaligned lanes are silently aligned down below, never trapped
    assign misalign = 1'b0;
`endif

    // Access width mask and aligned starting lane
    always_comb begin
        eff_lane = lane;
        bmask    = 64'h0000_0000_0000_00FF;
        case (size[1:0])
            2'b00: begin
                bmask    = 64'h0000_0000_0000_00FF;
                eff_lane = lane;
            end
            2'b01: begin
                bmask    = 64'h0000_0000_0000_FFFF;
                eff_lane = {lane[2:1], 1'b0};
            end
            2'b10: begin
                bmask    = 64'h0000_0000_FFFF_FFFF;
                eff_lane = {lane[2], 2'b00};
            end
            default: begin
                bmask    = '1;
                eff_lane = 3'b000;
            end
        endcase
    end

    assign shamt = {eff_lane, 3'b000};
    assign raw   = rdata >> shamt;
    assign wmask = bmask << shamt;
    assign err   = (size == SZ_ILL) || misalign;

    // Load extension and store merge; errors suppress both
    always_comb begin
        ld_data = '0;
        wr_word = rdata;
        if (!err) begin
            case (size)
                SZ_B:    ld_data = {{56{raw[7]}}, raw[7:0]};
                SZ_H:    ld_data = {{48{raw[15]}}, raw[15:0]};
                SZ_W:    ld_data = {{32{raw[31]}}, raw[31:0]};
                SZ_D:    ld_data = raw;
                SZ_BU:   ld_data = {56'd0, raw[7:0]};
                SZ_HU:   ld_data = {48'd0, raw[15:0]};
                SZ_WU:   ld_data = {32'd0, raw[31:0]};
                default: ld_data = '0;
            endcase
            wr_word = (rdata & ~wmask) | ((wdata << shamt) & wmask);
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Synthesizable target for the core's MEM_* request interface. Captures one
// load/store, waits LATENCY cycles, then returns a single MEM_R pulse with
// aligned/extended load data or performs the byte-merged store.
// Build option MEM_MISALIGN_TRAP_EN (see mem_lane_align) selects trapping
// versus forced alignment of misaligned accesses.
//
// state | meaning
// IDLE  | waiting for MEM_V; captures the request
// WAIT  | counting down the wait-state latency
// RESP  | store/load performed, MEM_R registered on this edge
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
)
(
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        MEM_V,
    input  logic        MEM_Cst_R_W,
    input  logic [2:0]  MEM_Cst_Size,
    input  logic [63:0] MEM_RES,
    input  logic [63:0] MEM_Address,
    output logic [63:0] MEM_Data_Out,
    output logic        MEM_R,
    output logic        MEM_Err
);

    localparam int         AW  = $clog2(DEPTH);
    localparam logic [3:0] LAT = 4'(LATENCY);

    resp_state_t state_q, state_nxt;
    logic [3:0]    cnt_q;
    logic          rw_q;
    logic [2:0]    size_q;
    logic [AW+2:0] addr_q;
    logic [63:0]   wdata_q;
    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] idx;
    logic [63:0]   rd_word;
    logic [63:0]   ld_data;
    logic [63:0]   wr_word;
    logic          lane_err;
    logic          we;
    logic          r_nxt;
    logic          err_nxt;
    logic [63:0]   data_nxt;
    logic          capture;
    logic          unused_addr;

    // Address bits above the array wrap and are deliberately dropped
    assign unused_addr = ^MEM_Address[63:AW+3];

    assign capture = (state_q == IDLE) && MEM_V;
    assign idx     = addr_q[AW+2:3];
    assign rd_word = mem[idx];

    mem_lane_align u_lane (
        .size    (size_q),
        .lane    (addr_q[2:0]),
        .rdata   (rd_word),
        .wdata   (wdata_q),
        .ld_data (ld_data),
        .wr_word (wr_word),
        .err     (lane_err)
    );

    // State register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state_q <= IDLE;
        else          state_q <= state_nxt;
    end

    // Next-state decode; WAIT exits on terminal count of 1
    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            IDLE:    if (MEM_V) state_nxt = (LAT == 4'd0) ? RESP : WAIT;
            WAIT:    if (cnt_q <= 4'd1) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Response decode: pulse, error, store enable and next load data
    always_comb begin
        we       = 1'b0;
        r_nxt    = 1'b0;
        err_nxt  = 1'b0;
        data_nxt = MEM_Data_Out;
        if (state_q == RESP) begin
            r_nxt   = 1'b1;
            err_nxt = lane_err;
            if (rw_q == MEM_STORE) we = !lane_err;
            else                   data_nxt = ld_data;
        end
    end

    // Wait-state down-counter
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)              cnt_q <= 4'd0;
        else if (capture)          cnt_q <= LAT;
        else if (state_q == WAIT)  cnt_q <= cnt_q - 4'd1;
    end

    // Request capture; later input changes are ignored
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rw_q    <= MEM_LOAD;
            size_q  <= SZ_B;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (capture) begin
            rw_q    <= MEM_Cst_R_W;
            size_q  <= MEM_Cst_Size;
            addr_q  <= MEM_Address[AW+2:0];
            wdata_q <= MEM_RES;
        end
    end

    // Registered response outputs
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            MEM_R        <= 1'b0;
            MEM_Err      <= 1'b0;
            MEM_Data_Out <= '0;
        end else begin
            MEM_R        <= r_nxt;
            MEM_Err      <= err_nxt;
            MEM_Data_Out <= data_nxt;
        end
    end

    // Storage array, never reset; a reset before RESP drops the store
    always_ff @(posedge CLK) begin
        if (we) mem[idx] <= wr_word;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: vector table of loads/stores with
// hand-computed results, plus sequences for reset abort and zero latency.
module tb_mem_responder;
    import mem_pkg::*;

`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        MEM_V;
    logic        v0;
    logic        rw;
    logic [2:0]  size;
    logic [63:0] wdata;
    logic [63:0] addr;
    logic [63:0] dout, dout0;
    logic        r, r0, e, e0;

    always #5 CLK = ~CLK;

    mem_responder #(.DEPTH(1024), .LATENCY(2)) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .MEM_V        (MEM_V),
        .MEM_Cst_R_W  (rw),
        .MEM_Cst_Size (size),
        .MEM_RES      (wdata),
        .MEM_Address  (addr),
        .MEM_Data_Out (dout),
        .MEM_R        (r),
        .MEM_Err      (e)
    );

    mem_responder #(.DEPTH(16), .LATENCY(0)) dut0 (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .MEM_V        (v0),
        .MEM_Cst_R_W  (rw),
        .MEM_Cst_Size (size),
        .MEM_RES      (wdata),
        .MEM_Address  (addr),
        .MEM_Data_Out (dout0),
        .MEM_R        (r0),
        .MEM_Err      (e0)
    );

    typedef struct {
        string       name;
        logic        rw;
        logic [2:0]  sz;
        logic [63:0] a;
        logic [63:0] wd;
        logic [63:0] exp;
        logic        err;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input string n, input logic w, input logic [2:0] s,
                       input logic [63:0] a, input logic [63:0] wd,
                       input logic [63:0] x, input logic er);
        vec_t v;
        v.name = n; v.rw = w; v.sz = s; v.a = a; v.wd = wd; v.exp = x; v.err = er;
        vecs.push_back(v);
    endtask

    // Issue one request (called #1 after a rising edge); k = edges from
    // the sampling edge until MEM_R is seen.
    task automatic do_req(input bit sel, input logic rw_i, input logic [2:0] sz,
                          input logic [63:0] a, input logic [63:0] wd,
                          output logic [63:0] d, output logic er, output int k);
        bit got;
        rw = rw_i; size = sz; addr = a; wdata = wd;
        if (sel) v0 = 1'b1; else MEM_V = 1'b1;
        @(posedge CLK); #1;
        rw = ~rw_i; size = 3'($urandom); addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
        k = 0; got = 1'b0;
        while (k < 40 && !got) begin
            @(posedge CLK); #1;
            k++;
            got = sel ? r0 : r;
        end
        if (!got) begin
            errors++; checks++;
            $display("FAIL timeout: no MEM_R after %0d cycles, required one", k);
        end
        d  = sel ? dout0 : dout;
        er = sel ? e0 : e;
        MEM_V = 1'b0; v0 = 1'b0;
        @(posedge CLK); #1;
        chk("pulse_width", {63'd0, (sel ? r0 : r)}, 64'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] d;
        logic        er;
        int          k;
        logic [63:0] last_ld;
        logic [63:0] exp_d;

        RESET_N = 1'b0; MEM_V = 1'b0; v0 = 1'b0; rw = 1'b0; size = SZ_D;
        wdata = '0; addr = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_r",    {63'd0, r},  64'd0);
        chk("rst_err",  {63'd0, e},  64'd0);
        chk("rst_data", dout,        64'd0);
        chk("rst_r0",   {63'd0, r0}, 64'd0);
        chk("rst_data0", dout0,      64'd0);
        RESET_N = 1'b1;
        @(posedge CLK); #1;

        add("sd_80",   MEM_STORE, SZ_D,  64'h80, 64'h1122_3344_5566_7788, 0, 1'b0);
        add("sb_83",   MEM_STORE, SZ_B,  64'h83, 64'h1234_5678_9ABC_DEF0, 0, 1'b0);
        add("lb_83",   MEM_LOAD,  SZ_B,  64'h83, 0, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0);
        add("lbu_83",  MEM_LOAD,  SZ_BU, 64'h83, 0, 64'h0000_0000_0000_00F0, 1'b0);
        add("ld_80",   MEM_LOAD,  SZ_D,  64'h80, 0, 64'h1122_3344_F066_7788, 1'b0);
        add("lb_81",   MEM_LOAD,  SZ_B,  64'h81, 0, 64'h0000_0000_0000_0077, 1'b0);
        add("lh_86",   MEM_LOAD,  SZ_H,  64'h86, 0, 64'h0000_0000_0000_1122, 1'b0);
        add("lh_82",   MEM_LOAD,  SZ_H,  64'h82, 0, 64'hFFFF_FFFF_FFFF_F066, 1'b0);
        add("lhu_82",  MEM_LOAD,  SZ_HU, 64'h82, 0, 64'h0000_0000_0000_F066, 1'b0);
        add("lw_84",   MEM_LOAD,  SZ_W,  64'h84, 0, 64'h0000_0000_1122_3344, 1'b0);
        add("sw_90",   MEM_STORE, SZ_W,  64'h90, 64'hFFFF_FFFF_8000_0000, 0, 1'b0);
        add("lwu_90",  MEM_LOAD,  SZ_WU, 64'h90, 0, 64'h0000_0000_8000_0000, 1'b0);
        add("lw_90",   MEM_LOAD,  SZ_W,  64'h90, 0, 64'hFFFF_FFFF_8000_0000, 1'b0);
        add("ill_st",  MEM_STORE, SZ_ILL, 64'h80, 64'h0, 0, 1'b1);
        add("ld_80b",  MEM_LOAD,  SZ_D,  64'h80, 0, 64'h1122_3344_F066_7788, 1'b0);
        add("ill_ld",  MEM_LOAD,  SZ_ILL, 64'h80, 0, 64'h0, 1'b1);
        add("lw_82",   MEM_LOAD,  SZ_W,  64'h82, 0,
            TRAP ? 64'h0 : 64'hFFFF_FFFF_F066_7788, TRAP);
        add("ld_85",   MEM_LOAD,  SZ_D,  64'h85, 0,
            TRAP ? 64'h0 : 64'h1122_3344_F066_7788, TRAP);
        add("ld_alias", MEM_LOAD, SZ_D,  64'h80 + 64'd8 * 64'd1024, 0, 64'h1122_3344_F066_7788, 1'b0);
        add("ld_hi",   MEM_LOAD,  SZ_D,  64'hFFFF_0000_0000_2080, 0, 64'h1122_3344_F066_7788, 1'b0);
        add("sd_88",   MEM_STORE, SZ_D,  64'h88, 64'h0, 0, 1'b0);
        add("sh_8a",   MEM_STORE, SZ_H,  64'h8A, 64'h7777_7777_7777_BEEF, 0, 1'b0);
        add("ld_88",   MEM_LOAD,  SZ_D,  64'h88, 0, 64'h0000_0000_BEEF_0000, 1'b0);

        last_ld = 64'd0;
        foreach (vecs[i]) begin
            do_req(1'b0, vecs[i].rw, vecs[i].sz, vecs[i].a, vecs[i].wd, d, er, k);
            chk({vecs[i].name, "_lat"}, 64'(k), 64'd3);
            chk({vecs[i].name, "_err"}, {63'd0, er}, {63'd0, vecs[i].err});
            exp_d = (vecs[i].rw == MEM_STORE) ? last_ld : vecs[i].exp;
            chk({vecs[i].name, "_data"}, d, exp_d);
            if (vecs[i].rw == MEM_LOAD) last_ld = vecs[i].exp;
        end

        // Reset in the middle of a store's wait phase drops the store
        do_req(1'b0, MEM_STORE, SZ_D, 64'h40, 64'h0123_4567_89AB_CDEF, d, er, k);
        rw = MEM_STORE; size = SZ_D; addr = 64'h40; wdata = 64'hDEAD_BEEF_0000_0001;
        MEM_V = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RESET_N = 1'b0; MEM_V = 1'b0;
        #1;
        chk("abort_r",    {63'd0, r}, 64'd0);
        chk("abort_data", dout,       64'd0);
        repeat (3) begin
            @(posedge CLK); #1;
            chk("abort_r_hold", {63'd0, r}, 64'd0);
        end
        RESET_N = 1'b1;
        @(posedge CLK); #1;
        chk("abort_idle_r", {63'd0, r}, 64'd0);
        do_req(1'b0, MEM_LOAD, SZ_D, 64'h40, 0, d, er, k);
        chk("abort_ld", d, 64'h0123_4567_89AB_CDEF);
        chk("abort_lat", 64'(k), 64'd3);

        // Zero-latency instance, DEPTH=16 so addresses wrap every 0x80
        do_req(1'b1, MEM_STORE, SZ_D, 64'h18, 64'hCAFE_F00D_8765_4321, d, er, k);
        chk("l0_st_lat", 64'(k), 64'd1);
        chk("l0_st_err", {63'd0, er}, 64'd0);
        do_req(1'b1, MEM_LOAD, SZ_D, 64'h98, 0, d, er, k);
        chk("l0_ld_lat", 64'(k), 64'd1);
        chk("l0_ld_alias", d, 64'hCAFE_F00D_8765_4321);
        do_req(1'b1, MEM_LOAD, SZ_WU, 64'h1C, 0, d, er, k);
        chk("l0_lwu", d, 64'h0000_0000_CAFE_F00D);
        do_req(1'b1, MEM_LOAD, SZ_ILL, 64'h18, 0, d, er, k);
        chk("l0_ill_err", {63'd0, er}, 64'd1);
        chk("l0_ill_data", d, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
